// File: rtl/ram_pkg.sv
// ram_pkg: constants and types shared by the RAM4K FIFO controller files.
//   DATA_W / ADDR_W / RAM_DEPTH : geometry of the 4K x 16 RAM behind the FIFO.
//   word_t / addr_t / cnt_t     : word, RAM address and occupancy types.
//   RW_READ / RW_WRITE          : encoding of the RAM rw pin.
package ram_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 12;
  localparam int RAM_DEPTH = 4096;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ADDR_W:0]   cnt_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/ram4k_fifo_ptr.sv
// ram4k_fifo_ptr: wrapping pointer used for the FIFO write and read addresses.
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset, pointer returns to 0
//   clr_i   : synchronous clear to 0 (wins over inc_i)
//   inc_i   : advance by one, wrapping modulo 2**W
//   value_o : current pointer value
module ram4k_fifo_ptr
  import ram_pkg::*;
#(
  parameter int W = ADDR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] value_o
);

  logic [W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr_i) begin
      value_d = '0;
    end else if (inc_i) begin
      // Natural binary overflow gives the 4095 -> 0 wrap.
      value_d = value_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/ram4k_fifo_ctrl.sv
// ram4k_fifo_ctrl: turns a single-port 4K x 16 RAM into a circular FIFO with
// valid/ready handshakes on both sides and a registered head word.
// Ports:
//   clk, rst                          : clock, asynchronous active-high reset
//   push_valid/push_ready/push_data   : producer side
//   pop_valid/pop_ready/pop_data      : consumer side, pop_data is registered
//   count, almost_full                : words held (RAM + output register)
//   ram_en/ram_rw/ram_address/ram_in  : RAM control, one access per cycle
//   ram_out                           : RAM read data (combinational read)
// Build option: define RAM4K_FIFO_BYPASS_EN to let a push into a completely
// empty (or draining) FIFO load the output register directly, skipping the RAM.
module ram4k_fifo_ctrl
  import ram_pkg::*;
#(
  parameter int DATA_W    = ram_pkg::DATA_W,
  parameter int ADDR_W    = ram_pkg::ADDR_W,
  parameter int AFULL_LVL = 4032
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] pop_data,
  output logic [ADDR_W:0]   count,
  output logic              almost_full,
  output logic              ram_en,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out
);

  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W+1)'(AFULL_LVL);

  logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              afull_q;
  logic              pop_valid_q, pop_valid_d;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              fill, push_acc, pop_acc, bypass, wr_en;

  ram4k_fifo_ptr #(.W(ADDR_W)) u_wr_ptr (
    .clk(clk), .rst(rst), .clr_i(1'b0), .inc_i(wr_en), .value_o(wr_ptr)
  );

  ram4k_fifo_ptr #(.W(ADDR_W)) u_rd_ptr (
    .clk(clk), .rst(rst), .clr_i(1'b0), .inc_i(fill), .value_o(rd_ptr)
  );

  always_comb begin
    // Refill the output register whenever it is empty or being consumed.
    fill       = (ram_cnt_q != '0) && (!pop_valid_q || pop_ready);
    // Gating with rst keeps ram_en low while reset is held.
    push_ready = !rst && !fill && (ram_cnt_q != DEPTH_CNT);
    push_acc   = push_valid && push_ready;
    pop_acc    = pop_valid_q && pop_ready;
`ifdef RAM4K_FIFO_BYPASS_EN
    bypass     = push_acc && (ram_cnt_q == '0) && (!pop_valid_q || pop_ready);
`else
    bypass     = 1'b0;
`endif
    wr_en      = push_acc && !bypass;

    // RAM address/rw/data hold their last values on idle cycles.
    addr_d = addr_q;
    rw_d   = rw_q;
    din_d  = din_q;
    if (fill) begin
      addr_d = rd_ptr;
      rw_d   = RW_READ;
    end else if (wr_en) begin
      addr_d = wr_ptr;
      rw_d   = RW_WRITE;
      din_d  = push_data;
    end

    pop_valid_d = pop_valid_q;
    pop_data_d  = pop_data_q;
    if (fill) begin
      pop_valid_d = 1'b1;
      pop_data_d  = ram_out;
    end else if (bypass) begin
      pop_valid_d = 1'b1;
      pop_data_d  = push_data;
    end else if (pop_acc) begin
      pop_valid_d = 1'b0;
    end

    ram_cnt_d = ram_cnt_q;
    if (wr_en) begin
      ram_cnt_d = ram_cnt_q + (ADDR_W+1)'(1);
    end else if (fill) begin
      ram_cnt_d = ram_cnt_q - (ADDR_W+1)'(1);
    end

    count_d = ram_cnt_d + {{ADDR_W{1'b0}}, pop_valid_d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_cnt_q   <= '0;
      count_q     <= '0;
      afull_q     <= 1'b0;
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
      addr_q      <= '0;
      rw_q        <= RW_READ;
      din_q       <= '0;
    end else begin
      ram_cnt_q   <= ram_cnt_d;
      count_q     <= count_d;
      afull_q     <= (count_d >= AFULL_CNT);
      pop_valid_q <= pop_valid_d;
      pop_data_q  <= pop_data_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      din_q       <= din_d;
    end
  end

  assign ram_en      = fill || wr_en;
  assign ram_rw      = rw_d;
  assign ram_address = addr_d;
  assign ram_in      = din_d;
  assign pop_valid   = pop_valid_q;
  assign pop_data    = pop_data_q;
  assign count       = count_q;
  assign almost_full = afull_q;

endmodule

// File: doc/ram4k_fifo_ctrl.md
Name: ram4k_fifo_ctrl

Overview:
- Sequencer directly upstream of the 4K x 16 RAM (RAM4K): drives its en/rw/address/in and consumes its out.
- Turns the single-port RAM into a 4096-entry circular FIFO with valid/ready handshakes on both sides.
- Head word is prefetched into an output register, so the consumer sees registered data.
- At most one RAM access (read or write) per cycle.

Parameters:
- DATA_W, 16, word width; must match RAM data width.
- ADDR_W, 12, RAM address width; RAM depth = 2**ADDR_W.
- AFULL_LVL, 4032, almost_full asserts when count >= AFULL_LVL.

Ports:
- clk  in  1  rising-edge clock shared with the RAM.
- rst  in  1  asynchronous, active-high reset.
- push_valid  in  1  producer offers push_data.
- push_ready  out  1  controller accepts push_data this cycle.
- push_data  in  DATA_W  word to enqueue.
- pop_valid  out  1  pop_data holds the head word.
- pop_ready  in  1  consumer takes the head word.
- pop_data  out  DATA_W  registered head word.
- count  out  ADDR_W+1  words held (RAM plus output register), 0..4097.
- almost_full  out  1  count >= AFULL_LVL.
- ram_en  out  1  RAM enable.
- ram_rw  out  1  1 = write, 0 = read.
- ram_address  out  ADDR_W  RAM word address.
- ram_in  out  DATA_W  RAM write data.
- ram_out  in  DATA_W  RAM read data; combinational on address while en=1 and rw=0.

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, ram_cnt=0, pop_valid=0, pop_data=0, count=0, almost_full=0, ram_en=0. All outputs are held at these values while rst is high. RAM contents are not cleared; stale words are unreachable. Reset mid-transfer discards everything.
- Accepted push: push_valid & push_ready at a clock edge. Accepted pop: pop_valid & pop_ready at a clock edge.
- Refill condition (combinational): fill = (ram_cnt != 0) & (!pop_valid | pop_ready).
- Arbitration (reads have priority):
  - If fill: ram_en=1, ram_rw=0, ram_address=rd_ptr. At the edge, pop_data <= ram_out, pop_valid <= 1, rd_ptr++, ram_cnt--.
  - Else if push_valid & push_ready: ram_en=1, ram_rw=1, ram_address=wr_ptr, ram_in=push_data. At the edge, wr_ptr++, ram_cnt++.
  - Else: ram_en=0; ram_address, ram_rw and ram_in are held at their last values.
- push_ready = !fill & (ram_cnt != 2**ADDR_W). It is combinational and may depend on pop_ready.
- Pop without refill: an accepted pop with ram_cnt=0 sets pop_valid<=0. pop_data keeps its last value.
- Pop and refill together: an accepted pop with fill replaces the head in the same edge. pop_valid stays 1, so back-to-back pops run at 1 word/clk.
- Pointers wrap naturally modulo 2**ADDR_W (4095 -> 0). No other special handling.
- Full: ram_cnt=4096 -> push_ready=0; the output register may still hold one more word (capacity 4097).
- Empty: count=0 -> pop_valid=0, ram_en=0 unless a push is accepted.
- Latency without bypass:
  - First push into an empty FIFO is written at edge N, read at edge N+1; pop_valid=1 after edge N+1.
  - Sustained push while the consumer stalls runs at 1 word/clk.
  - Throughput under simultaneous push+pop is 1 word/clk total, shared between read and write, reads first.
- count = ram_cnt + pop_valid, registered. almost_full is registered from the next count value.
- A push attempted while push_ready=0 is ignored with no side effects.

Optional Feature:
- Macro: RAM4K_FIFO_BYPASS_EN.
- Defined: when ram_cnt=0 and (!pop_valid | pop_ready), push_ready=1 and an accepted push loads pop_data directly. There is no RAM write, ram_en=0 that cycle, and pop_valid=1 after a single edge. Otherwise behaviour is unchanged.
- Undefined: every word passes through the RAM; first-word latency is 2 edges.

Decomposition:
- Shared package ram_pkg:
  - DATA_W=16, ADDR_W=12, RAM_DEPTH=4096 constants.
  - typedef word_t (DATA_W bits), addr_t (ADDR_W bits), cnt_t (ADDR_W+1 bits).
  - Encodings RW_READ=0, RW_WRITE=1.
- One sub-module: ram4k_fifo_ptr, a reusable wrapping pointer/counter with inc, clr and value outputs, instantiated for wr_ptr and rd_ptr.
- Arbitration and the output register stay in the top module.

Test Plan:
- Reset mid-stream: push 5 words, assert rst for 1 cycle -> count=0, pop_valid=0, ram_en=0. A new push of 0xBEEF is the first word popped.
- Single word, bypass off: push 0x1234 at edge 0 -> ram_rw=1, addr 0 that cycle; ram_rw=0, addr 0 next cycle; pop_valid=1, pop_data=0x1234 after edge 1.
- Fill to capacity with pop_ready=0: push 4097 words 0..4096 -> push_ready=0 after the last push, count=4097, almost_full=1 from count 4032. The 4098th push is ignored.
- Wrap-around: push/pop 5000 words continuously -> output sequence exactly 0..4999, ram_address wraps 4095->0, no gaps or duplicates.
- Simultaneous push and pop while the RAM holds 3 words -> read wins the cycle (push_ready=0), pop_data advances every cycle, count decrements by 1 per accepted pop.
- Bypass on: empty FIFO, push 0xA5A5 -> pop_valid=1 after one edge, ram_en=0 that cycle, count=1.
